// File: rtl/bus_xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_xfer_pkg
// Description : Shared types for the bus transfer sequencer: FSM state enum,
//               queued command record and the command-rejection rule.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_xfer_pkg;

    localparam int C_BITS  = 8;
    localparam int C_NREGS = 8;
    localparam int C_IDXW  = $clog2(C_NREGS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } xfer_state_t;

    // Field widths track the package constants; the top-level BITS/NREGS
    // parameters must not exceed them.
    typedef struct packed {
        logic [C_IDXW-1:0] src;
        logic [C_IDXW-1:0] dst;
        logic              imm;
        logic [C_BITS-1:0] data;
    } xfer_cmd_t;

    function automatic logic cmd_rejected(input xfer_cmd_t c, input int nregs);
        logic w_bad_dst;
        logic w_bad_src;
        w_bad_dst = (int'(c.dst) >= nregs);
        w_bad_src = !c.imm && ((int'(c.src) >= nregs) || (c.src == c.dst));
        return w_bad_dst || w_bad_src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_xfer_ctrl_if
// Description : Command handshake and register-bus strobes of bus_xfer_ctrl.
//               master = controller side, slave = host / register-file side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_xfer_ctrl_if #(
    parameter int BITS  = bus_xfer_pkg::C_BITS,
    parameter int NREGS = bus_xfer_pkg::C_NREGS
);
    localparam int IDXW = $clog2(NREGS);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [IDXW-1:0]   cmd_src;
    logic [IDXW-1:0]   cmd_dst;
    logic              cmd_imm;
    logic [BITS-1:0]   cmd_data;
    logic [NREGS-1:0]  reg_en;
    logic [NREGS-1:0]  reg_set;
    logic [BITS-1:0]   bus_out;
    logic              bus_oe;
    logic [BITS-1:0]   bus_in;
    logic              xfer_done;
    logic [BITS-1:0]   xfer_data;
    logic              xfer_err;

    modport master (
        input  cmd_valid, cmd_src, cmd_dst, cmd_imm, cmd_data, bus_in,
        output cmd_ready, reg_en, reg_set, bus_out, bus_oe,
               xfer_done, xfer_data, xfer_err
    );

    modport slave (
        output cmd_valid, cmd_src, cmd_dst, cmd_imm, cmd_data, bus_in,
        input  cmd_ready, reg_en, reg_set, bus_out, bus_oe,
               xfer_done, xfer_data, xfer_err
    );

endinterface
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous FIFO of xfer_cmd_t with full/empty flags; push and
//               pop in the same cycle are both honoured even when full.
//               Only built when BUS_XFER_FIFO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef BUS_XFER_FIFO_EN
module cmd_fifo
    import bus_xfer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      i_push,
    input  wire xfer_cmd_t i_wdata,
    input  wire logic      i_pop,
    output xfer_cmd_t      o_rdata,
    output logic           o_full,
    output logic           o_empty
);

    localparam int AW = $clog2(DEPTH);

    xfer_cmd_t     r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule
`endif
`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_xfer_ctrl
// Description : Sequences register-to-register / immediate-to-register moves
//               on the shared data bus: DRIVE -> LOAD -> RELEASE per command.
//               Optional command queue enabled by BUS_XFER_FIFO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int BITS       = C_BITS,
    parameter int NREGS      = C_NREGS,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bus_xfer_ctrl_if.master bif
);

    localparam int IDXW = $clog2(NREGS);

    xfer_state_t      r_state;
    xfer_state_t      w_state_nxt;
    logic [NREGS-1:0] r_reg_en;
    logic [NREGS-1:0] r_reg_set;
    logic             r_bus_oe;
    logic [BITS-1:0]  r_bus_out;
    logic             r_done;
    logic             r_err;
    logic [BITS-1:0]  r_xfer_data;
    logic [IDXW-1:0]  r_cmd_dst;

    logic [NREGS-1:0] w_reg_en_nxt;
    logic [NREGS-1:0] w_reg_set_nxt;
    logic             w_bus_oe_nxt;
    logic [BITS-1:0]  w_bus_out_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_capture;
    logic             w_take;
    logic             w_avail;
    xfer_cmd_t        w_head;

    function automatic logic [NREGS-1:0] onehot(input logic [IDXW-1:0] idx);
        return {{(NREGS-1){1'b0}}, 1'b1} << idx;
    endfunction

`ifdef BUS_XFER_FIFO_EN
    logic      w_full;
    logic      w_empty;
    xfer_cmd_t w_push_cmd;

    assign w_push_cmd = '{src: bif.cmd_src, dst: bif.cmd_dst,
                          imm: bif.cmd_imm, data: bif.cmd_data};

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bif.cmd_valid && !w_full),
        .i_wdata (w_push_cmd),
        .i_pop   (w_take),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_avail       = !w_empty;
    assign bif.cmd_ready = !w_full;
`else
    assign w_head        = '{src: bif.cmd_src, dst: bif.cmd_dst,
                             imm: bif.cmd_imm, data: bif.cmd_data};
    assign w_avail       = bif.cmd_valid;
    // Accepting a command moves straight to DRIVE, so IDLE never holds one.
    assign bif.cmd_ready = (r_state == ST_IDLE);

    // FIFO_DEPTH only shapes the optional queue.
    if (FIFO_DEPTH < 1) begin : g_fifo_depth_unused
    end
`endif

    assign w_take = (r_state == ST_IDLE) && w_avail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and next-output values; all strobes are registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_reg_en_nxt  = '0;
        w_reg_set_nxt = '0;
        w_bus_oe_nxt  = 1'b0;
        w_bus_out_nxt = '0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    if (cmd_rejected(w_head, NREGS)) begin
                        w_state_nxt = ST_RELEASE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRIVE;
                        if (w_head.imm) begin
                            w_bus_oe_nxt  = 1'b1;
                            w_bus_out_nxt = w_head.data;
                        end else begin
                            w_reg_en_nxt  = onehot(w_head.src);
                        end
                    end
                end
            end
            ST_DRIVE: begin
                w_state_nxt   = ST_LOAD;
                w_reg_en_nxt  = r_reg_en;
                w_bus_oe_nxt  = r_bus_oe;
                w_bus_out_nxt = r_bus_out;
                w_reg_set_nxt = onehot(r_cmd_dst);
            end
            ST_LOAD: begin
                w_state_nxt = ST_RELEASE;
                w_done_nxt  = 1'b1;
                w_capture   = 1'b1;
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_en    <= '0;
            r_reg_set   <= '0;
            r_bus_oe    <= 1'b0;
            r_bus_out   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_xfer_data <= '0;
            r_cmd_dst   <= '0;
        end else begin
            r_reg_en  <= w_reg_en_nxt;
            r_reg_set <= w_reg_set_nxt;
            r_bus_oe  <= w_bus_oe_nxt;
            r_bus_out <= w_bus_out_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            if (w_capture) r_xfer_data <= bif.bus_in;
            if (w_take)    r_cmd_dst   <= w_head.dst;
        end
    end

    assign bif.reg_en    = r_reg_en;
    assign bif.reg_set   = r_reg_set;
    assign bif.bus_oe    = r_bus_oe;
    assign bif.bus_out   = r_bus_out;
    assign bif.xfer_done = r_done;
    assign bif.xfer_err  = r_err;
    assign bif.xfer_data = r_xfer_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_xfer_ctrl
// Description : Self-checking bench for bus_xfer_ctrl with a behavioural
//               register file on the shared bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_xfer_ctrl;

    localparam int BITS  = 8;
    localparam int NREGS = 8;
`ifdef BUS_XFER_FIFO_EN
    localparam int C_LAT = 1;
`else
    localparam int C_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_xfer_ctrl_if #(.BITS(BITS), .NREGS(NREGS)) bif();

    bus_xfer_ctrl #(
        .BITS       (BITS),
        .NREGS      (NREGS),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    // Register file model: wired-OR bus, loads on reg_set.
    logic [BITS-1:0] regs [NREGS];
    logic            pl_we  = 1'b0;
    logic [2:0]      pl_idx = '0;
    logic [BITS-1:0] pl_val = '0;

    always @(posedge clk) begin
        if (pl_we) regs[pl_idx] <= pl_val;
        for (int i = 0; i < NREGS; i++)
            if (bif.reg_set[i]) regs[i] <= bif.bus_in;
    end

    always_comb begin
        logic [BITS-1:0] v;
        v = '0;
        if (bif.bus_oe) v = v | bif.bus_out;
        for (int i = 0; i < NREGS; i++)
            if (bif.reg_en[i]) v = v | regs[i];
        bif.bus_in = v;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int n_viol = 0;
    logic prev_drv = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bif.bus_oe && (|bif.reg_en)) n_viol++;
            if ($countones(bif.reg_en) > 1 || $countones(bif.reg_set) > 1) n_viol++;
            if ((|bif.reg_set) && !prev_drv) n_viol++;
        end
        prev_drv = bif.bus_oe || (|bif.reg_en);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        while (!bif.cmd_ready && t < 20) begin
            step();
            t++;
        end
        if (!bif.cmd_ready) check({tag, " ready timeout"}, 32'(bif.cmd_ready), 32'd1);
    endtask

    // Offers one command, returns one cycle after the accepting edge.
    task automatic send(input logic imm, input logic [2:0] src, input logic [2:0] dst,
                        input logic [7:0] data, input string tag);
        bif.cmd_valid = 1'b1;
        bif.cmd_imm   = imm;
        bif.cmd_src   = src;
        bif.cmd_dst   = dst;
        bif.cmd_data  = data;
        wait_ready(tag);
        step();
        bif.cmd_valid = 1'b0;
        for (int j = 0; j < C_LAT; j++) step();
    endtask

    typedef struct {
        logic       imm;
        logic [2:0] src;
        logic [2:0] dst;
        logic [7:0] data;
        logic       exp_err;
        logic [7:0] exp_en;
        logic [7:0] exp_set;
        logic [7:0] exp_xdata;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vt [NVEC];

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] ob;
        ob = v.imm ? v.data : 8'h00;
        send(v.imm, v.src, v.dst, v.data, tag);
        if (v.exp_err) begin
            check({tag, " rej done"},  32'(bif.xfer_done), 32'd1);
            check({tag, " rej err"},   32'(bif.xfer_err),  32'd1);
            check({tag, " rej en"},    32'(bif.reg_en),    32'd0);
            check({tag, " rej set"},   32'(bif.reg_set),   32'd0);
            check({tag, " rej oe"},    32'(bif.bus_oe),    32'd0);
            check({tag, " rej xdata"}, 32'(bif.xfer_data), 32'(v.exp_xdata));
            step();
            check({tag, " rej done pulse"}, 32'(bif.xfer_done), 32'd0);
        end else begin
            check({tag, " drv en"},   32'(bif.reg_en),    32'(v.exp_en));
            check({tag, " drv set"},  32'(bif.reg_set),   32'd0);
            check({tag, " drv oe"},   32'(bif.bus_oe),    32'(v.imm));
            check({tag, " drv bus"},  32'(bif.bus_out),   32'(ob));
            check({tag, " drv done"}, 32'(bif.xfer_done), 32'd0);
            step();
            check({tag, " ld en"},    32'(bif.reg_en),    32'(v.exp_en));
            check({tag, " ld set"},   32'(bif.reg_set),   32'(v.exp_set));
            check({tag, " ld oe"},    32'(bif.bus_oe),    32'(v.imm));
            step();
            check({tag, " rel done"}, 32'(bif.xfer_done), 32'd1);
            check({tag, " rel err"},  32'(bif.xfer_err),  32'd0);
            check({tag, " rel xdata"},32'(bif.xfer_data), 32'(v.exp_xdata));
            check({tag, " rel strobes"}, 32'({bif.reg_en, bif.reg_set, 7'd0, bif.bus_oe}), 32'd0);
            check({tag, " dst reg"},  32'(regs[v.dst]),   32'(v.exp_xdata));
            step();
        end
    endtask

    initial begin
        // imm src dst data err en set xdata
        vt[0] = '{1'b0, 3'd2, 3'd5, 8'h00, 1'b0, 8'h04, 8'h20, 8'hA5};
        vt[1] = '{1'b1, 3'd0, 3'd0, 8'h3C, 1'b0, 8'h00, 8'h01, 8'h3C};
        vt[2] = '{1'b0, 3'd3, 3'd3, 8'h00, 1'b1, 8'h00, 8'h00, 8'h3C};
        vt[3] = '{1'b0, 3'd5, 3'd7, 8'h00, 1'b0, 8'h20, 8'h80, 8'hA5};
        vt[4] = '{1'b0, 3'd0, 3'd1, 8'h00, 1'b0, 8'h01, 8'h02, 8'h3C};
        vt[5] = '{1'b1, 3'd0, 3'd6, 8'hC3, 1'b0, 8'h00, 8'h40, 8'hC3};
        vt[6] = '{1'b0, 3'd6, 3'd2, 8'h00, 1'b0, 8'h40, 8'h04, 8'hC3};

        bif.cmd_valid = 1'b0;
        bif.cmd_imm   = 1'b0;
        bif.cmd_src   = '0;
        bif.cmd_dst   = '0;
        bif.cmd_data  = '0;

        // Preload reg i = 0x10+i, reg2 = 0xA5.
        for (int i = 0; i < NREGS; i++) begin
            pl_we  = 1'b1;
            pl_idx = 3'(i);
            pl_val = (i == 2) ? 8'hA5 : 8'(8'h10 + i);
            step();
        end
        pl_we = 1'b0;

        check("reset en",    32'(bif.reg_en),    32'd0);
        check("reset set",   32'(bif.reg_set),   32'd0);
        check("reset oe",    32'(bif.bus_oe),    32'd0);
        check("reset bus",   32'(bif.bus_out),   32'd0);
        check("reset done",  32'(bif.xfer_done), 32'd0);
        check("reset err",   32'(bif.xfer_err),  32'd0);
        check("reset xdata", 32'(bif.xfer_data), 32'd0);
        rst = 1'b0;
        step();
        check("idle ready", 32'(bif.cmd_ready), 32'd1);

        for (int k = 0; k < NVEC; k++) run_vec(vt[k], $sformatf("v%0d", k));

        // Reset while LOAD strobes are up: reg1 holds 0x3C, reg4 holds 0x14.
        send(1'b0, 3'd1, 3'd4, 8'h00, "rst");
        step();
        check("rst pre set", 32'(bif.reg_set), 32'h10);
        rst = 1'b1;
        #1;
        check("rst async en",  32'(bif.reg_en),    32'd0);
        check("rst async set", 32'(bif.reg_set),   32'd0);
        check("rst xdata",     32'(bif.xfer_data), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst no done %0d", i), 32'(bif.xfer_done), 32'd0);
            step();
        end
        check("rst dst kept", 32'(regs[4]), 32'h14);
        run_vec('{1'b0, 3'd1, 3'd4, 8'h00, 1'b0, 8'h02, 8'h10, 8'h3C}, "post_rst");

`ifdef BUS_XFER_FIFO_EN
        begin
            int acc, nd, last, drop;
            logic go;
            acc = 0; nd = 0; last = 0; drop = -1;
            bif.cmd_valid = 1'b1;
            bif.cmd_imm   = 1'b1;
            bif.cmd_src   = '0;
            bif.cmd_dst   = 3'd0;
            bif.cmd_data  = 8'h50;
            for (int t = 0; t < 80 && nd < 6; t++) begin
                if (bif.xfer_done) begin
                    check($sformatf("fifo xdata %0d", nd), 32'(bif.xfer_data), 32'(8'h50 + nd));
                    if (nd > 0) check($sformatf("fifo gap %0d", nd), 32'(t - last), 32'd4);
                    last = t;
                    nd++;
                end
                go = bif.cmd_valid && bif.cmd_ready;
                if (bif.cmd_valid && !bif.cmd_ready && drop < 0) drop = acc;
                step();
                if (go) begin
                    acc++;
                    bif.cmd_dst   = 3'(acc);
                    bif.cmd_data  = 8'(8'h50 + acc);
                    bif.cmd_valid = (acc < 6);
                end
            end
            check("fifo ready drop", 32'(drop), 32'd5);
            check("fifo completions", 32'(nd), 32'd6);
        end
`else
        begin
            int nready, ndone;
            nready = 0; ndone = 0;
            bif.cmd_valid = 1'b1;
            bif.cmd_imm   = 1'b0;
            bif.cmd_src   = 3'd4;
            bif.cmd_dst   = 3'd3;
            for (int t = 0; t < 16; t++) begin
                if (bif.cmd_ready) nready++;
                if (bif.xfer_done) ndone++;
                step();
            end
            bif.cmd_valid = 1'b0;
            check("cont ready count", 32'(nready), 32'd4);
            check("cont done count",  32'(ndone),  32'd4);
            step();
        end
`endif
        repeat (4) step();
        check("bus monitor violations", 32'(n_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Sequencer that drives the shared tri-state data bus built from `register` instances: for each queued command it enables exactly one source onto the bus, then strobes the load input of one destination register. Sources can be a register or an immediate value driven by the controller itself. It sits between the host-facing command path and the register file of the vector accelerator. It is the only block that generates per-register output-enable and load strobes.

## Interface
- `BITS`, 8, data bus width
- `NREGS`, 8, number of bus registers; index width `IDXW = $clog2(NREGS)`
- `FIFO_DEPTH`, 4, command queue depth (power of two; used only with the FIFO feature)

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at a rising `clk` edge.
- `cmd_src` in IDXW: source register index; ignored when `cmd_imm`.
- `cmd_dst` in IDXW: destination register index.
- `cmd_imm` in 1: source is `cmd_data`, driven by the controller.
- `cmd_data` in BITS: immediate value.
- `reg_en` out NREGS: one-hot or zero; output enables of registers.
- `reg_set` out NREGS: one-hot or zero; load strobes of registers.
- `bus_out` out BITS: controller's bus drive value.
- `bus_oe` out 1: controller drives the bus; the top level resolves `bus_out` onto the bus.
- `bus_in` in BITS: resolved bus value.
- `xfer_done` out 1: one-cycle pulse when a transfer completes.
- `xfer_data` out BITS: bus value captured at the load strobe; held until the next completion.
- `xfer_err` out 1: one-cycle pulse with `xfer_done` for a rejected command.

## Operation
- States: IDLE, DRIVE, LOAD, RELEASE.
- IDLE: when a command is available, latch it and go to DRIVE.
- DRIVE (1 cycle): assert `reg_en[src]` (or `bus_oe` with `bus_out=data` if imm); `reg_set` = 0. Go to LOAD.
- LOAD (1 cycle):
  - Hold the enable and assert `reg_set[dst]`.
  - Capture `bus_in` into `xfer_data`.
  - Go to RELEASE.
- RELEASE (1 cycle): all `reg_en`, `reg_set`, `bus_oe` = 0 (bus turnaround); pulse `xfer_done`. Return to IDLE.
- Rejected commands:
  - Covers non-imm `src == dst`, and any index ≥ NREGS.
  - The command is consumed and no strobes are driven.
  - Go directly to RELEASE and pulse `xfer_done` and `xfer_err`; `xfer_data` is unchanged.
- Invariants:
  - At most one of {any `reg_en` bit, `bus_oe`} is high in any cycle.
  - `reg_set` is never high unless a source has been enabled for at least one prior cycle.
- All outputs are registered, so strobes are glitch-free.

## Timing
- Reset values: `reg_en`=0, `reg_set`=0, `bus_oe`=0, `bus_out`=0, `xfer_done`=0, `xfer_err`=0, `xfer_data`=0. State = IDLE, queue empty.
- Reset mid-transfer: every strobe drops asynchronously. The in-flight command is lost, with no `xfer_done`.
- Latency: from accept edge, DRIVE in cycle +1, LOAD in +2, `xfer_done` in +3. The next DRIVE follows no earlier than +4, so throughput is 1 transfer per 4 cycles.
- `cmd_ready` without FIFO: high only in IDLE with no command pending; combinational from state, not from `cmd_valid`.

## Configuration
- `BUS_XFER_FIFO_EN`:
  - Defined: a FIFO_DEPTH-entry command queue sits in front of the FSM. `cmd_ready` = queue not full.
  - Defined, full queue: a simultaneous push and pop is allowed and is accepted.
  - Defined, empty queue: a push is visible to the FSM the next cycle.
  - Undefined: no queue; the single command register is loaded only in IDLE, and `FIFO_DEPTH` is unused.

## Structure
- Package `bus_xfer_pkg`:
  - State enum `xfer_state_t`.
  - Command struct `xfer_cmd_t` (src, dst, imm, data).
- Sub-module `cmd_fifo` (parameterized synchronous FIFO of `xfer_cmd_t`, full/empty flags), instantiated only under `BUS_XFER_FIFO_EN`.

## Test plan
- Reset release, then cmd src=2, dst=5, reg2=0xA5:
  - `reg_en`=0x04 at +1 and +2.
  - `reg_set`=0x20 at +2.
  - reg5=0xA5.
  - `xfer_done` and `xfer_data`=0xA5 at +3.
- Immediate cmd dst=0, data=0x3C:
  - `bus_oe`=1 and `reg_en`=0 throughout.
  - reg0=0x3C.
  - `xfer_data`=0x3C.
- Cmd src=3, dst=3 (non-imm) → no strobes; `xfer_done`+`xfer_err` at +1; `xfer_data` unchanged.
- `rst` asserted during LOAD → `reg_set`/`reg_en` zero immediately; no `xfer_done`; next command executes normally.
- With `BUS_XFER_FIFO_EN`, 6 back-to-back commands at depth 4:
  - `cmd_ready` drops after 5 accepts.
  - All 6 complete in order at 4-cycle spacing.
- Without the macro, continuous `cmd_valid`: `cmd_ready` high one cycle in four; a bus monitor never sees two drivers or a set without a prior-cycle enable.
